nanci_write_commit: RTL and testbench

NANCI_WRITE_COMMIT -- requirements
Module: nanci_write_commit

---
 rtl/nanci_pkg.sv | 43 ++++
 rtl/nanci_phase_counter.sv | 36 +++
 rtl/nanci_write_commit.sv | 131 +++++++++++++
 tb/tb_nanci_write_commit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nanci_pkg.sv
// nanci_pkg: shared definitions for the NANCI write-commit slice.
//   - FSM state encoding for the per-PE sort/commit round
//   - packet field position helpers derived from ADDR_WIDTH/DATA_WIDTH
//   - default-width field positions for the standard 6+6 packet
package nanci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SORTING = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DONE    = 2'd3
  } nanci_state_e;

  // Phase counter width; SORT_CYCLES is limited to 1..255.
  localparam int CNT_W      = 8;
  localparam int COMMIT_MAX = 255;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 6;

  // Packet layout: {address, data}, data in the low bits.
  function automatic int pkt_data_lsb();
    return 0;
  endfunction

  function automatic int pkt_data_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic int pkt_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int pkt_addr_msb(input int aw, input int dw);
    return aw + dw - 1;
  endfunction

  localparam int PKT_DATA_LSB = 0;
  localparam int PKT_DATA_MSB = DEF_DATA_W - 1;
  localparam int PKT_ADDR_LSB = DEF_DATA_W;
  localparam int PKT_ADDR_MSB = DEF_ADDR_W + DEF_DATA_W - 1;

endpackage

// File: rtl/nanci_phase_counter.sv
// nanci_phase_counter: counts the cycles of the mesh sort phase.
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   clr_i  - synchronous clear to 0 (dominates en_i)
//   en_i   - increment enable
//   tc_o   - terminal count: counter == SORT_CYCLES-1
module nanci_phase_counter
  import nanci_pkg::*;
#(
  parameter int SORT_CYCLES = 53
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SORT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/nanci_write_commit.sv
// nanci_write_commit: per-PE commit stage of the NANCI mesh sort.
// A start pulse opens a round: SORT_CYCLES cycles of sorting (packet
// inputs ignored), one COMMIT cycle where the sorted packet is written to
// local memory if it is addressed to this PE, then DONE until next start.
//   clk          - clock
//   rst          - synchronous active-high reset, dominates everything
//   start        - one-cycle round request (honoured in IDLE/DONE only)
//   pkt_valid    - sorted packet present at this PE
//   pkt_in       - {address, data}
//   memory       - PE-local storage word
//   busy         - round in progress (SORTING or COMMIT)
//   done         - round finished (DONE)
//   addr_miss    - sticky: last commit saw a packet for another PE
//   commit_count - successful writes, saturating at 255
module nanci_write_commit
  import nanci_pkg::*;
#(
  parameter int N           = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 6,
  parameter int SORT_CYCLES = 53,
  parameter int PE_ID       = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             pkt_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] pkt_in,
  output logic [DATA_WIDTH-1:0]            memory,
  output logic                             busy,
  output logic                             done,
  output logic                             addr_miss,
  output logic [7:0]                       commit_count
);

  localparam int AMSB = pkt_addr_msb(ADDR_WIDTH, DATA_WIDTH);
  localparam int ALSB = pkt_addr_lsb(DATA_WIDTH);
  localparam int DMSB = pkt_data_msb(DATA_WIDTH);
  localparam int DLSB = pkt_data_lsb();

  // Compare against the PE index truncated to the address field.
  localparam logic [ADDR_WIDTH-1:0] PE_ADDR = ADDR_WIDTH'(PE_ID);

  if (SORT_CYCLES < 1 || SORT_CYCLES > 255 || PE_ID < 0 || PE_ID >= N) begin : g_bad_param
    $error("nanci_write_commit: SORT_CYCLES or PE_ID out of range");
  end

  nanci_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q, mem_d;
  logic                  miss_q, miss_d;
  logic [7:0]            ccnt_q, ccnt_d;
  logic                  cnt_clr, cnt_en, cnt_tc;

  logic [ADDR_WIDTH-1:0] pkt_addr;
  logic [DATA_WIDTH-1:0] pkt_data;
  assign pkt_addr = pkt_in[AMSB:ALSB];
  assign pkt_data = pkt_in[DMSB:DLSB];

  nanci_phase_counter #(
    .SORT_CYCLES(SORT_CYCLES)
  ) u_phase (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .tc_o (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    miss_d  = miss_q;
    ccnt_d  = ccnt_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SORTING;
          cnt_clr = 1'b1;
        end
      end
      ST_SORTING: begin
        // Counter reads 0 in the first sorting cycle, so hitting
        // SORT_CYCLES-1 gives exactly SORT_CYCLES cycles here.
        cnt_en = 1'b1;
        if (cnt_tc) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_DONE;
        if (pkt_valid) begin
          if (pkt_addr == PE_ADDR) begin
            mem_d = pkt_data;
            if (ccnt_q != 8'(COMMIT_MAX)) ccnt_d = ccnt_q + 8'd1;
          end else begin
            miss_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_SORTING;
          cnt_clr = 1'b1;
          miss_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mem_q   <= '0;
      miss_q  <= 1'b0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      miss_q  <= miss_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign memory       = mem_q;
  assign addr_miss    = miss_q;
  assign commit_count = ccnt_q;
  assign busy         = (state_q == ST_SORTING) || (state_q == ST_COMMIT);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_nanci_write_commit.sv
module tb_nanci_write_commit;
  localparam int SC = 53;
  localparam int PE = 5;

  logic        clk = 1'b0;
  logic        rst, start, pkt_valid;
  logic [11:0] pkt_in;
  logic [5:0]  memory;
  logic        busy, done, addr_miss;
  logic [7:0]  commit_count;

  nanci_write_commit #(
    .N(64), .ADDR_WIDTH(6), .DATA_WIDTH(6), .SORT_CYCLES(SC), .PE_ID(PE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_valid(pkt_valid),
    .pkt_in(pkt_in), .memory(memory), .busy(busy), .done(done),
    .addr_miss(addr_miss), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: architectural state after each completed round.
  logic [5:0] m_mem;
  logic       m_miss;
  int         m_cnt;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; pkt_valid = 1'b1; pkt_in = {6'(PE), 6'd33};
    @(negedge clk);
    rst = 1'b0; start = 1'b0; pkt_valid = 1'b0; pkt_in = '0;
    m_mem = '0; m_miss = 1'b0; m_cnt = 0;
  endtask

  // One full round; noisy drives random start/packet junk while the
  // round is in flight, which must have no effect.
  task automatic run_round(input logic [5:0] a, input logic [5:0] d,
                           input logic v, input bit noisy, input string tag);
    int win;
    @(negedge clk);
    start = 1'b1; pkt_valid = 1'($urandom); pkt_in = 12'($urandom);
    @(posedge clk);
    win = 0;
    for (int j = 0; j <= SC; j++) begin
      @(negedge clk);
      if (j == 0) begin
        total_cnt++;
        if (addr_miss !== 1'b0)
          $display("FAIL %s miss_clr: addr_miss=%0b want 0", tag, addr_miss);
        else pass_cnt++;
      end
      if (busy === 1'b1 && done === 1'b0 && memory === m_mem) win++;
      start = noisy ? 1'($urandom) : 1'b0;
      if (j < SC) begin
        pkt_valid = noisy ? 1'($urandom) : 1'b0;
        pkt_in    = noisy ? 12'($urandom) : 12'd0;
      end else begin
        pkt_valid = v;
        pkt_in    = {a, d};
      end
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; pkt_valid = 1'b0;
    m_miss = 1'b0;
    if (v) begin
      if (a == 6'(PE)) begin
        m_mem = d;
        if (m_cnt < 255) m_cnt++;
      end else m_miss = 1'b1;
    end
    total_cnt++;
    if (win !== SC + 1) $display("FAIL %s busy_window: %0d cycles want %0d", tag, win, SC + 1);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL %s done: %0b want 1", tag, done);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s busy_end: %0b want 0", tag, busy);
    else pass_cnt++;
    total_cnt++;
    if (memory !== m_mem) $display("FAIL %s memory: %0d want %0d", tag, memory, m_mem);
    else pass_cnt++;
    total_cnt++;
    if (addr_miss !== m_miss) $display("FAIL %s addr_miss: %0b want %0b", tag, addr_miss, m_miss);
    else pass_cnt++;
    total_cnt++;
    if (commit_count !== 8'(m_cnt)) $display("FAIL %s commit_count: %0d want %0d", tag, commit_count, m_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) @(negedge clk);
    total_cnt++;
    if (memory !== 6'd0) $display("FAIL reset memory: %0d want 0", memory); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset done: %0b want 0", done); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset busy: %0b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (commit_count !== 8'd0) $display("FAIL reset commit_count: %0d want 0", commit_count); else pass_cnt++;
    total_cnt++;
    if (addr_miss !== 1'b0) $display("FAIL reset addr_miss: %0b want 0", addr_miss); else pass_cnt++;
  endtask

  task automatic test_match();
    run_round(6'd5, 6'd58, 1'b1, 1'b0, "match");
  endtask

  task automatic test_miss();
    run_round(6'd9, 6'd3, 1'b1, 1'b0, "miss");
    run_round(6'd5, 6'd17, 1'b1, 1'b0, "after_miss");
  endtask

  task automatic test_hole();
    run_round(6'd9, 6'd3, 1'b1, 1'b0, "pre_hole");
    run_round(6'd5, 6'd44, 1'b0, 1'b0, "hole");
  endtask

  task automatic test_restart_ignored();
    run_round(6'd5, 6'd11, 1'b1, 1'b1, "noisy_match");
    run_round(6'd63, 6'd11, 1'b1, 1'b1, "noisy_miss");
  endtask

  task automatic test_rst_abort();
    run_round(6'd5, 6'd21, 1'b1, 1'b0, "pre_abort");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1; start = 1'b1; pkt_valid = 1'b1; pkt_in = {6'(PE), 6'd7};
    @(negedge clk);
    rst = 1'b0; start = 1'b0; pkt_valid = 1'b1; pkt_in = {6'(PE), 6'd7};
    m_mem = '0; m_miss = 1'b0; m_cnt = 0;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort state: busy=%0b done=%0b want 0/0", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (memory !== 6'd0) $display("FAIL abort memory: %0d want 0", memory); else pass_cnt++;
    total_cnt++;
    if (commit_count !== 8'd0) $display("FAIL abort commit_count: %0d want 0", commit_count); else pass_cnt++;
    repeat (SC + 5) @(negedge clk);
    pkt_valid = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || memory !== 6'd0)
      $display("FAIL abort no_commit: done=%0b busy=%0b memory=%0d want 0/0/0", done, busy, memory);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [5:0] a, d;
    logic v;
    for (int i = 0; i < 12; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 6'(PE) : 6'($urandom);
      d = 6'($urandom);
      v = ($urandom_range(0, 3) != 0);
      run_round(a, d, v, 1'($urandom), "random");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 256; i++)
      run_round(6'd5, 6'($urandom), 1'b1, 1'b0, "sat");
    total_cnt++;
    if (commit_count !== 8'd255) $display("FAIL saturate: %0d want 255", commit_count);
    else pass_cnt++;
    run_round(6'd5, 6'd2, 1'b1, 1'b0, "sat_hold");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pkt_valid = 1'b0; pkt_in = '0;
    m_mem = '0; m_miss = 1'b0; m_cnt = 0;
    test_reset();
    test_match();
    test_miss();
    test_hole();
    test_restart_ignored();
    test_rst_abort();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
